// File: rtl/noc_switch3_rr.sv
// Three-port hierarchical NoC switch: per-input FWFT FIFOs, destination-range routing and
// packet-aware round-robin arbitration on each output. Port 1 = top, 2 = bottom, 3 = right.
module noc_switch3_rr #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned TopMin    = 1,
  parameter int unsigned TopMax    = 1,
  parameter int unsigned BottomMin = 0,
  parameter int unsigned BottomMax = 0,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic [DataWidth-1:0] i_data3,
  input  logic                 i_last1,
  input  logic                 i_last2,
  input  logic                 i_last3,
  input  logic                 i_data_valid1,
  input  logic                 i_data_valid2,
  input  logic                 i_data_valid3,
  output logic                 o_data_ready1,
  output logic                 o_data_ready2,
  output logic                 o_data_ready3,
  output logic [DataWidth-1:0] o_data1,
  output logic [DataWidth-1:0] o_data2,
  output logic [DataWidth-1:0] o_data3,
  output logic                 o_last1,
  output logic                 o_last2,
  output logic                 o_last3,
  output logic                 o_data_valid1,
  output logic                 o_data_valid2,
  output logic                 o_data_valid3,
  input  logic                 i_data_ready1,
  input  logic                 i_data_ready2,
  input  logic                 i_data_ready3,
  output logic                 o_route_err,
  output logic [CntWidth-1:0]  o_drop_cnt
);

  localparam int unsigned FlitWidth = DataWidth + 1;
  localparam int unsigned IdxWidth  = $clog2(FifoDepth);
  localparam int unsigned PtrWidth  = IdxWidth + 1;

  localparam logic [AddrWidth-1:0] TopLo  = AddrWidth'(TopMin);
  localparam logic [AddrWidth-1:0] TopSpn = AddrWidth'(TopMax - TopMin);
  localparam logic [AddrWidth-1:0] BotLo  = AddrWidth'(BottomMin);
  localparam logic [AddrWidth-1:0] BotSpn = AddrWidth'(BottomMax - BottomMin);

  logic [DataWidth-1:0] in_data [3];
  logic                 in_last [3];
  logic                 in_valid [3];
  logic                 in_ready [3];
  logic                 out_ready [3];
  logic [DataWidth-1:0] out_data [3];
  logic                 out_last [3];
  logic                 out_valid [3];

  assign in_data[0]   = i_data1;
  assign in_data[1]   = i_data2;
  assign in_data[2]   = i_data3;
  assign in_last[0]   = i_last1;
  assign in_last[1]   = i_last2;
  assign in_last[2]   = i_last3;
  assign in_valid[0]  = i_data_valid1;
  assign in_valid[1]  = i_data_valid2;
  assign in_valid[2]  = i_data_valid3;
  assign out_ready[0] = i_data_ready1;
  assign out_ready[1] = i_data_ready2;
  assign out_ready[2] = i_data_ready3;

  assign o_data_ready1 = in_ready[0];
  assign o_data_ready2 = in_ready[1];
  assign o_data_ready3 = in_ready[2];
  assign o_data1       = out_data[0];
  assign o_data2       = out_data[1];
  assign o_data3       = out_data[2];
  assign o_last1       = out_last[0];
  assign o_last2       = out_last[1];
  assign o_last3       = out_last[2];
  assign o_data_valid1 = out_valid[0];
  assign o_data_valid2 = out_valid[1];
  assign o_data_valid3 = out_valid[2];

  // ---------------------------------------------------------------------------------------------
  // Input FIFOs (first-word fall-through)
  // ---------------------------------------------------------------------------------------------
  logic [FlitWidth-1:0] head [3];
  logic                 empty [3];
  logic                 pop [3];

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [FlitWidth-1:0] mem_q [FifoDepth];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic                 full, push;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full        = (wr_ptr_q[IdxWidth] != rd_ptr_q[IdxWidth]) &&
                         (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]);
    assign empty[g]    = (wr_ptr_q == rd_ptr_q);
    assign in_ready[g] = ~full & ~i_reset;
    assign push        = in_valid[g] & in_ready[g];
    assign head[g]     = mem_q[rd_ptr_q[IdxWidth-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[g]) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[IdxWidth-1:0]] <= {in_last[g], in_data[g]};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Routing: one-hot request vector per input, bit o = wants output o
  // ---------------------------------------------------------------------------------------------
  logic [AddrWidth-1:0] dest [3];
  logic                 hit_top [3];
  logic                 hit_bot [3];
  logic [2:0]           req [3];
  logic                 drop;

  for (genvar g = 0; g < 3; g++) begin : g_dec
    logic [AddrWidth-1:0] top_off, bot_off;
    assign dest[g]    = head[g][DataWidth-1 -: AddrWidth];
    // Offset compare gives an inclusive range test without a constant-true bound check.
    assign top_off    = dest[g] - TopLo;
    assign bot_off    = dest[g] - BotLo;
    assign hit_top[g] = (top_off <= TopSpn);
    assign hit_bot[g] = (bot_off <= BotSpn);
  end

  always_comb begin
    req[0] = 3'b000;
    req[1] = 3'b000;
    req[2] = 3'b000;
    drop   = 1'b0;
    if (!empty[0]) req[0] = hit_bot[0] ? 3'b010 : 3'b100;
    if (!empty[1]) req[1] = hit_top[1] ? 3'b001 : 3'b100;
    if (!empty[2]) begin
      if (hit_top[2])      req[2] = 3'b001;
      else if (hit_bot[2]) req[2] = 3'b010;
      else                 drop   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-output packet-aware round-robin arbiters; candidate A is the lower-numbered input
  // ---------------------------------------------------------------------------------------------
  logic acc_a [3];
  logic acc_b [3];

  for (genvar o = 0; o < 3; o++) begin : g_arb
    localparam int unsigned CandA = (o == 0) ? 1 : 0;
    localparam int unsigned CandB = (o == 2) ? 1 : 2;

    logic locked_q, lock_sel_q, prio_q;
    logic req_a, req_b, sel, accept;

    assign req_a = req[CandA][o];
    assign req_b = req[CandB][o];

    always_comb begin
      sel = 1'b0;
      if (locked_q)                         sel = lock_sel_q;
      else if (prio_q ? req_b : req_a)      sel = prio_q;
      else                                  sel = ~prio_q;
    end

    assign out_valid[o] = sel ? req_b : req_a;
    assign out_data[o]  = sel ? head[CandB][DataWidth-1:0] : head[CandA][DataWidth-1:0];
    assign out_last[o]  = sel ? head[CandB][DataWidth] : head[CandA][DataWidth];
    assign accept       = out_valid[o] & out_ready[o];
    assign acc_a[o]     = accept & ~sel;
    assign acc_b[o]     = accept & sel;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        locked_q   <= 1'b0;
        lock_sel_q <= 1'b0;
        prio_q     <= 1'b0;
      end else if (accept) begin
        if (out_last[o]) begin
          locked_q <= 1'b0;
          prio_q   <= ~sel;
        end else begin
          locked_q   <= 1'b1;
          lock_sel_q <= sel;
        end
      end
    end
  end

  // Each head routes to exactly one output, so at most one term per input is ever set.
  assign pop[0] = acc_a[1] | acc_a[2];
  assign pop[1] = acc_a[0] | acc_b[2];
  assign pop[2] = acc_b[0] | acc_b[1] | drop;

  // ---------------------------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_route_err <= 1'b0;
      o_drop_cnt  <= '0;
    end else if (drop) begin
      o_route_err <= 1'b1;
      if (o_drop_cnt != {CntWidth{1'b1}}) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_switch3_rr.sv
// Directed-vector bench for noc_switch3_rr: routing, arbitration order, backpressure,
// concurrency, drop saturation and asynchronous reset.
module tb_noc_switch3_rr;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data1, i_data2, i_data3;
  logic          i_last1, i_last2, i_last3;
  logic          i_valid1, i_valid2, i_valid3;
  logic          o_ready1, o_ready2, o_ready3;
  logic [DW-1:0] o_data1, o_data2, o_data3;
  logic          o_last1, o_last2, o_last3;
  logic          o_valid1, o_valid2, o_valid3;
  logic          i_ready1, i_ready2, i_ready3;
  logic          route_err;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  noc_switch3_rr dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_data1       (i_data1),
    .i_data2       (i_data2),
    .i_data3       (i_data3),
    .i_last1       (i_last1),
    .i_last2       (i_last2),
    .i_last3       (i_last3),
    .i_data_valid1 (i_valid1),
    .i_data_valid2 (i_valid2),
    .i_data_valid3 (i_valid3),
    .o_data_ready1 (o_ready1),
    .o_data_ready2 (o_ready2),
    .o_data_ready3 (o_ready3),
    .o_data1       (o_data1),
    .o_data2       (o_data2),
    .o_data3       (o_data3),
    .o_last1       (o_last1),
    .o_last2       (o_last2),
    .o_last3       (o_last3),
    .o_data_valid1 (o_valid1),
    .o_data_valid2 (o_valid2),
    .o_data_valid3 (o_valid3),
    .i_data_ready1 (i_ready1),
    .i_data_ready2 (i_ready2),
    .i_data_ready3 (i_ready3),
    .o_route_err   (route_err),
    .o_drop_cnt    (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic [7:0] d, input logic [7:0] s,
                                         input logic [15:0] idx);
    return {d, s, idx};
  endfunction

  // Output transfers observed at the falling edge, i.e. those that complete on the next rise.
  logic [DW:0] q1[$], q2[$], q3[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid1 && i_ready1) q1.push_back({o_last1, o_data1});
      if (o_valid2 && i_ready2) q2.push_back({o_last2, o_data2});
      if (o_valid3 && i_ready3) q3.push_back({o_last3, o_data3});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  task automatic wait_q(input int port, input int n);
    int sz;
    for (int k = 0; k < 100; k++) begin
      sz = (port == 1) ? q1.size() : (port == 2) ? q2.size() : q3.size();
      if (sz >= n) break;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          acc;
  logic [DW:0] exp_f;
  logic [7:0]  src;

  initial begin
    rst = 1'b1;
    {i_valid1, i_valid2, i_valid3} = 3'b000;
    {i_last1, i_last2, i_last3}    = 3'b000;
    i_data1 = '0; i_data2 = '0; i_data3 = '0;
    {i_ready1, i_ready2, i_ready3} = 3'b111;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {o_ready1, o_ready2, o_ready3}, 3'b000);
    check("rst_valid", {o_valid1, o_valid2, o_valid3}, 3'b000);
    check("rst_err", route_err, 1'b0);
    check("rst_cnt", drop_cnt, 16'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {o_ready1, o_ready2, o_ready3}, 3'b111);
    tick();

    // Single flit D=0 on right input goes to bottom, one cycle after the handshake
    i_data3 = flit(8'h00, 8'h03, 16'h0055); i_last3 = 1'b1; i_valid3 = 1'b1;
    tick();
    i_valid3 = 1'b0;
    @(negedge clk);
    check("single_valid", {o_valid1, o_valid2, o_valid3}, 3'b010);
    check("single_data", o_data2, flit(8'h00, 8'h03, 16'h0055));
    check("single_last", o_last2, 1'b1);
    tick();
    @(negedge clk);
    check("single_drained", o_valid2, 1'b0);
    tick();

    // Unroutable flit on the right input is dropped
    i_data3 = flit(8'h05, 8'h03, 16'h0001); i_last3 = 1'b1; i_valid3 = 1'b1;
    tick();
    i_valid3 = 1'b0;
    @(negedge clk);
    check("drop_no_valid", {o_valid1, o_valid2, o_valid3}, 3'b000);
    tick();
    check("drop_err", route_err, 1'b1);
    check("drop_cnt1", drop_cnt, 16'h1);

    // Two 3-flit packets to top; reset priority favours input 2
    clear_q();
    for (int i = 0; i < 3; i++) begin
      i_data2 = flit(8'h01, 8'h02, 16'(i)); i_last2 = (i == 2); i_valid2 = 1'b1;
      i_data3 = flit(8'h01, 8'h03, 16'(i)); i_last3 = (i == 2); i_valid3 = 1'b1;
      tick();
    end
    i_valid2 = 1'b0; i_valid3 = 1'b0;
    wait_q(1, 6);
    check("arb_count", q1.size(), 6);
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      src   = (k < 3) ? 8'h02 : 8'h03;
      exp_f = {(k % 3) == 2, flit(8'h01, src, 16'(k % 3))};
      check("arb_order", q1[k], exp_f);
    end

    // Single flit from input 2 flips top priority to input 3
    i_data2 = flit(8'h01, 8'h02, 16'h0009); i_last2 = 1'b1; i_valid2 = 1'b1;
    tick();
    i_valid2 = 1'b0;
    wait_q(1, 7);
    clear_q();
    for (int i = 0; i < 2; i++) begin
      i_data2 = flit(8'h01, 8'h02, 16'(i)); i_last2 = (i == 1); i_valid2 = 1'b1;
      i_data3 = flit(8'h01, 8'h03, 16'(i)); i_last3 = (i == 1); i_valid3 = 1'b1;
      tick();
    end
    i_valid2 = 1'b0; i_valid3 = 1'b0;
    wait_q(1, 4);
    check("flip_count", q1.size(), 4);
    for (int k = 0; k < 4 && k < q1.size(); k++) begin
      src   = (k < 2) ? 8'h03 : 8'h02;
      exp_f = {(k % 2) == 1, flit(8'h01, src, 16'(k % 2))};
      check("flip_order", q1[k], exp_f);
    end

    // Backpressure: right output stalled, input 1 fills its FIFO
    clear_q();
    i_ready3 = 1'b0;
    acc = 0;
    for (int i = 0; i < FD + 1; i++) begin
      i_data1 = flit(8'h02, 8'h01, 16'(i)); i_last1 = 1'b1; i_valid1 = 1'b1;
      @(negedge clk);
      if (o_ready1) acc++;
      tick();
    end
    i_valid1 = 1'b0;
    check("bp_accepts", acc, FD);
    check("bp_ready_low", o_ready1, 1'b0);
    check("bp_no_out", q3.size(), 0);
    i_ready3 = 1'b1;
    repeat (FD) @(posedge clk);
    check("bp_drain_rate", q3.size(), FD);
    for (int k = 0; k < FD && k < q3.size(); k++)
      check("bp_drain_order", q3[k], {1'b1, flit(8'h02, 8'h01, 16'(k))});
    #1;
    @(negedge clk);
    check("bp_empty", o_valid3, 1'b0);
    check("bp_ready_back", o_ready1, 1'b1);
    tick();

    // All three outputs busy concurrently
    clear_q();
    for (int k = 0; k < 4; k++) begin
      i_data1 = flit(8'h00, 8'h01, 16'(k)); i_last1 = 1'b1; i_valid1 = 1'b1;
      i_data2 = flit(8'h02, 8'h02, 16'(k)); i_last2 = 1'b1; i_valid2 = 1'b1;
      i_data3 = flit(8'h01, 8'h03, 16'(k)); i_last3 = 1'b1; i_valid3 = 1'b1;
      tick();
      @(negedge clk);
      check("conc_all_valid", {o_valid1, o_valid2, o_valid3}, 3'b111);
    end
    {i_valid1, i_valid2, i_valid3} = 3'b000;
    tick();
    wait_q(1, 4); wait_q(2, 4); wait_q(3, 4);
    check("conc_top_n", q1.size(), 4);
    check("conc_bot_n", q2.size(), 4);
    check("conc_right_n", q3.size(), 4);
    if (q1.size() == 4) check("conc_top_last", q1[3], {1'b1, flit(8'h01, 8'h03, 16'd3)});
    if (q2.size() == 4) check("conc_bot_last", q2[3], {1'b1, flit(8'h00, 8'h01, 16'd3)});
    if (q3.size() == 4) check("conc_right_last", q3[3], {1'b1, flit(8'h02, 8'h02, 16'd3)});

    // Lock top to input 3 (priority now input 3), then reset mid-packet
    i_data2 = flit(8'h01, 8'h02, 16'h0020); i_last2 = 1'b1; i_valid2 = 1'b1;
    tick();
    i_valid2 = 1'b0;
    repeat (2) tick();
    i_data3 = flit(8'h01, 8'h03, 16'h0030); i_last3 = 1'b0; i_valid3 = 1'b1;
    tick();
    i_valid3 = 1'b0;
    repeat (2) tick();
    i_data2 = flit(8'h01, 8'h02, 16'h0021); i_last2 = 1'b1; i_valid2 = 1'b1;
    tick();
    i_valid2 = 1'b0;
    @(negedge clk);
    check("lock_gap", o_valid1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {o_valid1, o_valid2, o_valid3}, 3'b000);
    check("async_rst_ready", {o_ready1, o_ready2, o_ready3}, 3'b000);
    tick();
    rst = 1'b0;
    clear_q();
    tick();
    i_data2 = flit(8'h01, 8'h02, 16'h0040); i_last2 = 1'b1; i_valid2 = 1'b1;
    i_data3 = flit(8'h01, 8'h03, 16'h0041); i_last3 = 1'b1; i_valid3 = 1'b1;
    tick();
    {i_valid2, i_valid3} = 2'b00;
    wait_q(1, 2);
    check("rst_arb_n", q1.size(), 2);
    if (q1.size() >= 2) begin
      check("rst_arb_first", q1[0], {1'b1, flit(8'h01, 8'h02, 16'h0040)});
      check("rst_arb_second", q1[1], {1'b1, flit(8'h01, 8'h03, 16'h0041)});
    end

    // Drop counter saturation
    check("sat_cnt_cleared", drop_cnt, 16'h0);
    i_data3 = flit(8'h05, 8'h03, 16'h0); i_last3 = 1'b1; i_valid3 = 1'b1;
    repeat (70000) tick();
    i_valid3 = 1'b0;
    repeat (3) tick();
    check("sat_cnt", drop_cnt, 16'hFFFF);
    check("sat_err", route_err, 1'b1);
    check("sat_no_out", {o_valid1, o_valid2, o_valid3}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/noc_switch3_rr.md
Name: noc_switch3_rr

Overview:
- Parametrised next-generation 3-port hierarchical NoC switch.
- Ports: top (child 0), bottom (child 1), right (parent link).
- Each input has an internal first-word-fall-through FIFO. Flits are routed on a destination field at the top of the flit.
- Each output has a packet-aware round-robin arbiter that holds its grant until the packet's last flit. Unroutable flits from the parent link are dropped and counted.

Parameters:
- DataWidth, 32, flit payload width including destination field.
- AddrWidth, 8, destination field width; field = flit[DataWidth-1 -: AddrWidth].
- FifoDepth, 8, entries per input FIFO; power of 2, >= 2.
- TopMin, 1, lowest destination reachable via top.
- TopMax, 1, highest destination reachable via top.
- BottomMin, 0, lowest destination reachable via bottom.
- BottomMax, 0, highest destination reachable via bottom.
- CntWidth, 16, drop counter width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_data{1,2,3}  in  DataWidth  input flit (1 = top, 2 = bottom, 3 = right)
- i_last{1,2,3}  in  1  input flit is last of its packet
- i_data_valid{1,2,3}  in  1  input flit valid
- o_data_ready{1,2,3}  out  1  input FIFO not full
- o_data{1,2,3}  out  DataWidth  output flit
- o_last{1,2,3}  out  1  output last flag
- o_data_valid{1,2,3}  out  1  output flit valid
- i_data_ready{1,2,3}  in  1  downstream ready
- o_route_err  out  1  sticky: a right-port flit matched neither child range
- o_drop_cnt  out  CntWidth  count of dropped flits, saturating

Behaviour:
- Handshake: a transfer occurs when valid & ready are both high at a rising clock edge, on every port.
- Reset (asynchronous, active-high):
  - FIFOs emptied; all o_data_valid = 0; all o_data_ready = 0 while reset is asserted, 1 on the first cycle after release.
  - Locks cleared; arbiter priority to the lower-numbered input.
  - o_route_err = 0; o_drop_cnt = 0.
  - Reset mid-packet truncates the packet; no recovery is attempted.
- FIFO:
  - Width DataWidth+1 (flit + last).
  - o_data_readyN = !full, independent of read activity; a full FIFO accepts no write even if read in the same cycle.
  - A flit written at edge n appears at the head in cycle n+1 (min latency 1 cycle input to output valid).
  - Simultaneous read and write when not full keeps the occupancy constant.
- Routing on FIFO head destination D:
  - Input 1: TopMin<=D<=TopMax is not a legal target; if BottomMin<=D<=BottomMax -> bottom, else -> right.
  - Input 2: if TopMin<=D<=TopMax -> top, else -> right.
  - Input 3: top range -> top; else bottom range -> bottom; else drop. A drop pops the head in 1 cycle with no output activity, sets o_route_err, and increments o_drop_cnt, saturating at all-ones.
  - If ranges overlap, the top range has precedence for input 3.
- Arbitration, per output, between its two candidate inputs (top: 2,3; bottom: 1,3; right: 1,2):
  - Unlocked: grant = priority input if it requests, else the other input. Grant is combinational and costs no idle cycle.
  - When a non-last flit is accepted, the output locks to that input until its last flit is accepted.
  - On acceptance of a last flit: unlock, and priority moves to the other candidate.
  - A single-flit packet (last=1) never locks.
  - While locked, the other input waits even if the locked input's FIFO is empty; o_data_valid = 0 during such gaps.
- Outputs:
  - o_dataN / o_lastN = granted FIFO head.
  - o_data_validN = granted input has a head routed to N.
  - The FIFO pops on o_data_validN & i_data_readyN.
  - o_data and o_last are don't-care when valid = 0.
- Throughput: 1 flit/cycle per output; all three outputs may transfer in the same cycle.

Test Plan:
- Single flit D=0x00, last=1 on input 3, all outputs ready -> o_data_valid2 = 1 in the cycle after the input handshake, o_data2 equals the input flit, FIFO empty after.
- Inputs 2 and 3 each send 3-flit packets to D=0x01 simultaneously -> top output carries input-3 packet then input-2 packet, or input-2 first per the current priority, never interleaved; priority flips after each last flit.
- Input 3 flit D=0x05 (matches no child range) -> no output valid, o_route_err = 1, o_drop_cnt = 1; 70000 such flits with CntWidth=16 -> o_drop_cnt saturates at 0xFFFF.
- Hold i_data_ready3 = 0 and push FifoDepth+1 flits to right via input 1 -> o_data_ready1 goes 0 after FifoDepth accepts; raising ready drains all FifoDepth flits in order, one per cycle.
- Input 1 to bottom, input 2 to right, input 3 to top concurrently -> all three outputs transfer in the same cycle, 1 flit/cycle sustained.
- Assert i_reset mid-packet while top is locked -> all valids 0 immediately (asynchronous); after release, the top arbiter is unlocked and grants the lower-numbered input (input 2) first.
